// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the decode/EX stages and the pipeline sequencing controller.
// The master side drives the stage information; the slave side (the controller) returns the stall/flush controls.
interface pipe_hazard_ctrl_if #(
    parameter int MC_W   = 6,
    parameter int PERF_W = 16
);
    logic              id_reg1_read_i;
    logic [4:0]        id_reg1_addr_i;
    logic              id_reg2_read_i;
    logic [4:0]        id_reg2_addr_i;
    logic              ex_is_load_i;
    logic [4:0]        ex_wd_i;
    logic              ex_mc_start_i;
    logic [MC_W-1:0]   ex_mc_cycles_i;
    logic              flush_req_i;
    logic [31:0]       flush_pc_i;
    logic [5:0]        stall_o;
    logic              flush_o;
    logic [31:0]       new_pc_o;
    logic              busy_o;
    logic [PERF_W-1:0] stall_cnt_o;

    modport master (
        output id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
        output ex_is_load_i, ex_wd_i, ex_mc_start_i, ex_mc_cycles_i,
        output flush_req_i, flush_pc_i,
        input  stall_o, flush_o, new_pc_o, busy_o, stall_cnt_o
    );

    modport slave (
        input  id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
        input  ex_is_load_i, ex_wd_i, ex_mc_start_i, ex_mc_cycles_i,
        input  flush_req_i, flush_pc_i,
        output stall_o, flush_o, new_pc_o, busy_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, multi-cycle EX stalls and exception flushes,
// plus a saturating stall-cycle counter for performance debug.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_RUN     | normal issue; load-use and multi-cycle start are evaluated
// ST_MC_BUSY | multi-cycle EX op in flight; r_cnt cycles left to release
// ST_FLUSH   | one bubble cycle after a flush; hazards and MC start ignored
module pipe_hazard_ctrl #(
    parameter int MC_W   = 6,
    parameter int PERF_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MC_BUSY = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    localparam logic [5:0] STALL_MC   = 6'b001111;
    localparam logic [5:0] STALL_LOAD = 6'b000111;

    logic [1:0]        r_state;
    logic [MC_W-1:0]   r_cnt;
    logic [PERF_W-1:0] r_stall_cnt;

    logic [1:0]        w_state_nxt;
    logic [MC_W-1:0]   w_cnt_nxt;
    logic [5:0]        w_stall;
    logic              w_flush;
    logic [31:0]       w_new_pc;
    logic              w_hazard;

    always_comb begin
        w_hazard = bus.ex_is_load_i && (bus.ex_wd_i != 5'd0) &&
                   ((bus.id_reg1_read_i && (bus.id_reg1_addr_i == bus.ex_wd_i)) ||
                    (bus.id_reg2_read_i && (bus.id_reg2_addr_i == bus.ex_wd_i)));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 6'd0;
        w_flush     = 1'b0;
        w_new_pc    = 32'd0;
        if (rst) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
        end else if (bus.flush_req_i) begin
            // A flush aborts whatever is in flight, including an MC countdown.
            w_flush     = 1'b1;
            w_new_pc    = bus.flush_pc_i;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_FLUSH;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.ex_mc_start_i) begin
                        if (bus.ex_mc_cycles_i >= MC_W'(2)) begin
                            w_stall     = STALL_MC;
                            w_cnt_nxt   = bus.ex_mc_cycles_i - MC_W'(1);
                            w_state_nxt = ST_MC_BUSY;
                        end
                    end else if (w_hazard) begin
                        w_stall = STALL_LOAD;
                    end
                end
                ST_MC_BUSY: begin
                    if (r_cnt > MC_W'(1)) begin
                        w_stall   = STALL_MC;
                        w_cnt_nxt = r_cnt - MC_W'(1);
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    w_state_nxt = ST_RUN;
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if ((w_stall != 6'd0) && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            end
        end
    end

    assign bus.stall_o     = w_stall;
    assign bus.flush_o     = w_flush;
    assign bus.new_pc_o    = w_new_pc;
    assign bus.busy_o      = !rst && (r_state != ST_RUN);
    assign bus.stall_cnt_o = r_stall_cnt;

endmodule
